// File: rtl/shim_cfg_pkg.sv
// Shared constants for the AXI->SPI configuration synchronizer.
//   *_W                  field widths of the carried configuration
//   DEFAULT_*            default synchronizer depth and stability filter length
//   F_*                  bit positions of each field in the per-field status vectors
//   LOCK_MASK            fields that are frozen while the SPI system is enabled
package shim_cfg_pkg;

    localparam int THRESH_W = 15;
    localparam int WINDOW_W = 32;
    localparam int SKIP_W   = 16;
    localparam int NCS_W    = 8;

    localparam int DEFAULT_DEPTH        = 3;
    localparam int DEFAULT_STABLE_COUNT = 2;

    localparam int NUM_FIELDS = 8;

    localparam int F_SPI_EN     = 0;
    localparam int F_BLOCK_BUFS = 1;
    localparam int F_THRESH     = 2;
    localparam int F_WINDOW     = 3;
    localparam int F_INTEG_EN   = 4;
    localparam int F_SKIP       = 5;
    localparam int F_DAC_NCS    = 6;
    localparam int F_ADC_NCS    = 7;

    // spi_en and block_bufs are never frozen
    localparam logic [NUM_FIELDS-1:0] LOCK_MASK = 8'b1111_1100;

endpackage

// File: rtl/shim_cfg_field_sync.sv
// One configuration field: DEPTH-flop synchronizer followed by a stability filter.
//   clk, rst   SPI-domain clock, async active-high reset
//   din        field value from the AXI domain (asynchronous)
//   hold       1 = keep dout even if a new value has settled
//   dout       filtered, registered copy of din
//   settled    synced value has been unchanged for STABLE_COUNT cycles
//   diff       settled value differs from dout
module shim_cfg_field_sync #(
    parameter int WIDTH        = 1,
    parameter int DEPTH        = 3,
    parameter int STABLE_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             hold,
    output logic [WIDTH-1:0] dout,
    output logic             settled,
    output logic             diff
);

    localparam int CW = $clog2(STABLE_COUNT + 1);

    logic [DEPTH-1:0][WIDTH-1:0] sync_q;
    logic [DEPTH-1:0]            vld_pipe;
    logic [CW-1:0]               cnt_q;
    logic [WIDTH-1:0]            s;

    assign s       = sync_q[DEPTH-1];
    assign settled = (cnt_q == CW'(STABLE_COUNT));
    assign diff    = settled && (s != dout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            vld_pipe <= '0;
            cnt_q    <= '0;
            dout     <= '0;
        end else begin
            sync_q   <= {sync_q[DEPTH-2:0], din};
            // Marks chain stages holding a real sample; the reset contents of
            // the chain must not count towards stability.
            vld_pipe <= {vld_pipe[DEPTH-2:0], 1'b1};
            // The stage feeding s is compared so the counter restarts on the
            // same edge that s takes a new value.
            if (vld_pipe[DEPTH-1] && (sync_q[DEPTH-2] == s)) begin
                if (!settled)
                    cnt_q <= cnt_q + CW'(1);
            end else begin
                cnt_q <= '0;
            end
            if (settled && !hold)
                dout <= s;
        end
    end

endmodule

// File: rtl/shim_spi_cfg_sync.sv
// AXI->SPI quasi-static configuration synchronizer, spi_clk domain only.
//   spi_clk, spi_rst              clock, async active-high reset
//   spi_en, block_bufs, integ_*,  AXI-domain configuration inputs
//   boot_test_skip, *_n_cs_high_time
//   <field>_stable                filtered SPI-domain copies
//   cfg_valid                     every field has settled at least once since reset
//   cfg_lock_viol                 sticky: a locked field changed while enabled
module shim_spi_cfg_sync
    import shim_cfg_pkg::*;
#(
    parameter int DEPTH        = DEFAULT_DEPTH,
    parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
    input  logic                spi_clk,
    input  logic                spi_rst,
    input  logic                spi_en,
    input  logic                block_bufs,
    input  logic [THRESH_W-1:0] integ_thresh_avg,
    input  logic [WINDOW_W-1:0] integ_window,
    input  logic                integ_en,
    input  logic [SKIP_W-1:0]   boot_test_skip,
    input  logic [NCS_W-1:0]    dac_n_cs_high_time,
    input  logic [NCS_W-1:0]    adc_n_cs_high_time,
    output logic                spi_en_stable,
    output logic                block_bufs_stable,
    output logic [THRESH_W-1:0] integ_thresh_avg_stable,
    output logic [WINDOW_W-1:0] integ_window_stable,
    output logic                integ_en_stable,
    output logic [SKIP_W-1:0]   boot_test_skip_stable,
    output logic [NCS_W-1:0]    dac_n_cs_high_time_stable,
    output logic [NCS_W-1:0]    adc_n_cs_high_time_stable,
    output logic                cfg_valid,
    output logic                cfg_lock_viol
);

    logic [NUM_FIELDS-1:0] settled_v;
    logic [NUM_FIELDS-1:0] diff_v;
    logic [NUM_FIELDS-1:0] seen_q;
    logic                  valid_nxt;
    logic                  en_nxt;
    logic                  lock_hold;

    assign valid_nxt = cfg_valid | (&(seen_q | settled_v));
    // spi_en is 1 bit wide, so its next value is the current one flipped
    // whenever a differing settled value is allowed through.
    assign en_nxt    = spi_en_stable ^ (diff_v[F_SPI_EN] & valid_nxt);
    // Locked on the rising edge (simultaneous settle stays locked) and on the
    // falling edge (unlocked fields load one cycle after the fall).
    assign lock_hold = spi_en_stable | en_nxt;

    shim_cfg_field_sync #(.WIDTH(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_spi_en (
        .clk(spi_clk), .rst(spi_rst), .din(spi_en), .hold(~valid_nxt),
        .dout(spi_en_stable), .settled(settled_v[F_SPI_EN]), .diff(diff_v[F_SPI_EN]));

    shim_cfg_field_sync #(.WIDTH(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_block_bufs (
        .clk(spi_clk), .rst(spi_rst), .din(block_bufs), .hold(1'b0),
        .dout(block_bufs_stable), .settled(settled_v[F_BLOCK_BUFS]), .diff(diff_v[F_BLOCK_BUFS]));

    shim_cfg_field_sync #(.WIDTH(THRESH_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_thresh (
        .clk(spi_clk), .rst(spi_rst), .din(integ_thresh_avg), .hold(lock_hold),
        .dout(integ_thresh_avg_stable), .settled(settled_v[F_THRESH]), .diff(diff_v[F_THRESH]));

    shim_cfg_field_sync #(.WIDTH(WINDOW_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_window (
        .clk(spi_clk), .rst(spi_rst), .din(integ_window), .hold(lock_hold),
        .dout(integ_window_stable), .settled(settled_v[F_WINDOW]), .diff(diff_v[F_WINDOW]));

    shim_cfg_field_sync #(.WIDTH(1), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_integ_en (
        .clk(spi_clk), .rst(spi_rst), .din(integ_en), .hold(lock_hold),
        .dout(integ_en_stable), .settled(settled_v[F_INTEG_EN]), .diff(diff_v[F_INTEG_EN]));

    shim_cfg_field_sync #(.WIDTH(SKIP_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_skip (
        .clk(spi_clk), .rst(spi_rst), .din(boot_test_skip), .hold(lock_hold),
        .dout(boot_test_skip_stable), .settled(settled_v[F_SKIP]), .diff(diff_v[F_SKIP]));

    shim_cfg_field_sync #(.WIDTH(NCS_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_dac_ncs (
        .clk(spi_clk), .rst(spi_rst), .din(dac_n_cs_high_time), .hold(lock_hold),
        .dout(dac_n_cs_high_time_stable), .settled(settled_v[F_DAC_NCS]), .diff(diff_v[F_DAC_NCS]));

    shim_cfg_field_sync #(.WIDTH(NCS_W), .DEPTH(DEPTH), .STABLE_COUNT(STABLE_COUNT)) u_adc_ncs (
        .clk(spi_clk), .rst(spi_rst), .din(adc_n_cs_high_time), .hold(lock_hold),
        .dout(adc_n_cs_high_time_stable), .settled(settled_v[F_ADC_NCS]), .diff(diff_v[F_ADC_NCS]));

    always_ff @(posedge spi_clk or posedge spi_rst) begin
        if (spi_rst) begin
            seen_q        <= '0;
            cfg_valid     <= 1'b0;
            cfg_lock_viol <= 1'b0;
        end else begin
            seen_q    <= seen_q | settled_v;
            cfg_valid <= valid_nxt;
            // Clearing on the falling edge of the enable takes priority.
            if (spi_en_stable && !en_nxt)
                cfg_lock_viol <= 1'b0;
            else if (lock_hold && (|(diff_v & LOCK_MASK)))
                cfg_lock_viol <= 1'b1;
        end
    end

endmodule
